// File: rtl/vnu_pe.sv
// ----------------------------------------------------------------------------
// vnu_pe : variable-node processing element for degree-3 LDPC columns.
//
// Holds one channel LLR, combines it with the three incoming CNU messages and
// sends each CNU its extrinsic message as {hard, sign, phi(mag)}. Iterates
// until MAX_ITER passes complete or (EARLY_STOP) the CNUs report parity ok.
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst        synchronous active-high reset
//   llr_valid  channel LLR offered (accepted only in IDLE)
//   llr_in     channel LLR, two's complement
//   llr_ready  high exactly while in IDLE
//   c_valid    CNU message set strobe (accepted only in WAIT_C)
//   C          CNU messages, sign-magnitude {sign, mag[3:0]}
//   p_ok       all parity checks satisfied, sampled with c_valid
//   X_out      to CNUs: {hard, extrinsic sign, phi(mag)}
//   x_valid    one-cycle pulse, X_out is new
//   hard_bit   current hard decision
//   done       one-cycle pulse with the final x_valid
//   iter_cnt   completed COMPUTE passes
// ----------------------------------------------------------------------------

// phi(x) = ln((e^x+1)/(e^x-1)); index has 2 fractional bits, result is
// rounded to 2 fractional bits and saturated at 15 (phi(0) is infinite).
module phi_lut (
   input  logic [5:0] i_idx,
   output logic [3:0] o_phi
);
   always_comb begin
      o_phi = '0;
      case (i_idx)
         6'd0:  o_phi = 4'd15;
         6'd1:  o_phi = 4'd8;
         6'd2:  o_phi = 4'd6;
         6'd3:  o_phi = 4'd4;
         6'd4:  o_phi = 4'd3;
         6'd5:  o_phi = 4'd2;
         6'd6:  o_phi = 4'd2;
         6'd7:  o_phi = 4'd1;
         6'd8:  o_phi = 4'd1;
         6'd9:  o_phi = 4'd1;
         6'd10: o_phi = 4'd1;
         6'd11: o_phi = 4'd1;
         default: o_phi = '0;
      endcase
   end
endmodule

module vnu_pe #(
   parameter int MAX_ITER   = 8,
   parameter int ITER_W     = 4,
   parameter int EARLY_STOP = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   llr_valid,
   input  logic [5:0]             llr_in,
   output logic                   llr_ready,
   input  logic                   c_valid,
   input  logic [2:0][4:0]        C,
   input  logic                   p_ok,
   output logic [2:0][5:0]        X_out,
   output logic                   x_valid,
   output logic                   hard_bit,
   output logic                   done,
   output logic [ITER_W-1:0]      iter_cnt
);

   typedef enum logic [2:0] {S_IDLE, S_INIT, S_WAIT_C, S_COMPUTE, S_DONE} state_t;

   state_t                r_state, w_next;
   logic [5:0]            r_llr;
   logic [2:0][4:0]       r_c;
   logic                  r_pok;
   logic [2:0][5:0]       r_x;
   logic                  r_xv, r_hard, r_done;
   logic [ITER_W-1:0]     r_iter;

   logic [ITER_W-1:0]     w_iter_inc;
   logic                  w_final;
   logic signed [7:0]     w_ci    [3];
   logic signed [7:0]     w_e     [3];
   logic signed [7:0]     w_abs   [3];
   logic [3:0]            w_mag   [3];
   logic [3:0]            w_phi   [3];
   logic [2:0]            w_sign;
   logic signed [7:0]     w_total;
   logic                  w_hard;

   assign w_iter_inc = r_iter + 1'b1;
   assign w_final    = (w_iter_inc == ITER_W'(MAX_ITER)) || ((EARLY_STOP != 0) && r_pok);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (llr_valid) w_next = S_INIT;
         S_INIT:    w_next = S_WAIT_C;
         S_WAIT_C:  if (c_valid) w_next = S_COMPUTE;
         S_COMPUTE: w_next = w_final ? S_DONE : S_WAIT_C;
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_llr <= '0;
         r_c   <= '0;
         r_pok <= 1'b0;
      end else begin
         if (r_state == S_IDLE && llr_valid) r_llr <= llr_in;
         if (r_state == S_WAIT_C && c_valid) begin
            r_c   <= C;
            r_pok <= p_ok;
         end
      end
   end

   // In INIT the incoming messages count as zero, so every e_i is the LLR.
   always_comb begin
      w_total = {{2{r_llr[5]}}, r_llr};
      w_sign  = '0;
      for (int unsigned i = 0; i < 3; i++) begin
         w_ci[i] = '0;
         if (r_state == S_COMPUTE)
            w_ci[i] = r_c[i][4] ? -$signed({4'b0000, r_c[i][3:0]})
                                :  $signed({4'b0000, r_c[i][3:0]});
         w_total = w_total + w_ci[i];
      end
      for (int unsigned i = 0; i < 3; i++) begin
         w_e[i]    = w_total - w_ci[i];
         w_sign[i] = w_e[i][7];
         w_abs[i]  = w_e[i][7] ? -w_e[i] : w_e[i];
         w_mag[i]  = (w_abs[i] > 8'sd15) ? 4'd15 : w_abs[i][3:0];
      end
      w_hard = w_total[7];
   end

   for (genvar g = 0; g < 3; g++) begin : g_lut
      phi_lut u_lut (
         .i_idx ({2'b00, w_mag[g]}),
         .o_phi (w_phi[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_x    <= '0;
         r_xv   <= 1'b0;
         r_hard <= 1'b0;
         r_done <= 1'b0;
         r_iter <= '0;
      end else begin
         r_xv   <= (r_state == S_INIT) || (r_state == S_COMPUTE);
         r_done <= (r_state == S_COMPUTE) && w_final;
         if (r_state == S_INIT || r_state == S_COMPUTE) begin
            for (int unsigned i = 0; i < 3; i++)
               r_x[i] <= {w_hard, w_sign[i], w_phi[i]};
            r_hard <= w_hard;
            r_iter <= (r_state == S_INIT) ? '0 : w_iter_inc;
         end
      end
   end

   assign llr_ready = (r_state == S_IDLE);
   assign X_out     = r_x;
   assign x_valid   = r_xv;
   assign hard_bit  = r_hard;
   assign done      = r_done;
   assign iter_cnt  = r_iter;

endmodule
